// File: rtl/z3_slave_sequencer_if.sv
// Zorro III slave-cycle bundle: buffered bus qualifiers and per-target decode in,
// cycle ownership and DTACK/BERR requests out.
interface z3_slave_sequencer_if #(
    parameter int NUM_TGT = 4
);
    logic               fcs_n;
    logic               read;
    logic [3:0]         ds_n;
    logic               validspace;
    logic [NUM_TGT-1:0] tgt_match;
    logic [NUM_TGT-1:0] tgt_ack;
    logic [NUM_TGT-1:0] tgt_sel;
    logic               dtack;
    logic               berr_req;
    logic               multi_hit;
    logic               abort;
    logic [7:0]         err_count;
    logic [2:0]         state;

    modport slave (
        input  fcs_n, read, ds_n, validspace, tgt_match, tgt_ack,
        output tgt_sel, dtack, berr_req, multi_hit, abort, err_count, state
    );

    modport master (
        output fcs_n, read, ds_n, validspace, tgt_match, tgt_ack,
        input  tgt_sel, dtack, berr_req, multi_hit, abort, err_count, state
    );
endinterface

// File: rtl/z3_slave_sequencer.sv
// Zorro III slave-cycle sequencer: picks one decoded target per FCS cycle, inserts
// programmable wait states, and converts a missing ack into a bus-error request.
module z3_slave_sequencer #(
    parameter int NUM_TGT  = 4,
    parameter int MIN_WAIT = 0,
    parameter int TIMEOUT  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    z3_slave_sequencer_if.slave    bus
);
    localparam int TO_W      = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1)) : 1;
    localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TO_W-1:0] TO_LAST = TO_LAST_I[TO_W-1:0];
    localparam logic [7:0]      WAIT_INIT = MIN_WAIT[7:0];

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_END   = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_TGT-1:0] tgt_sel_q, tgt_sel_d;
    logic               dtack_q, dtack_d;
    logic               berr_q, berr_d;
    logic               multi_hit_q, multi_hit_d;
    logic               abort_q, abort_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic [7:0]         wait_q, wait_d;
    logic [TO_W-1:0]    to_q, to_d;

    logic [NUM_TGT-1:0] first_hit;
    logic               multi;
    logic               seen;

    // Lowest index wins; a second set bit anywhere flags an overlapping decode.
    always_comb begin
        first_hit = '0;
        multi     = 1'b0;
        seen      = 1'b0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (bus.tgt_match[i]) begin
                if (!seen) first_hit[i] = 1'b1;
                if (seen)  multi = 1'b1;
                seen = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        tgt_sel_d   = tgt_sel_q;
        dtack_d     = dtack_q;
        berr_d      = berr_q;
        multi_hit_d = 1'b0;
        abort_d     = 1'b0;
        err_cnt_d   = err_cnt_q;
        wait_d      = wait_q;
        to_d        = to_q;
        case (state_q)
            S_IDLE: begin
                dtack_d   = 1'b0;
                berr_d    = 1'b0;
                tgt_sel_d = '0;
                if (!bus.fcs_n && bus.validspace && |bus.tgt_match) begin
                    tgt_sel_d   = first_hit;
                    multi_hit_d = multi;
                    state_d     = S_START;
                end
            end
            S_START: begin
                if (bus.fcs_n) begin
                    state_d   = S_IDLE;
                    tgt_sel_d = '0;
                    abort_d   = 1'b1;
                end else if (bus.read || bus.ds_n != 4'hF) begin
                    state_d = S_DATA;
                    wait_d  = WAIT_INIT;
                    to_d    = '0;
                end
            end
            S_DATA: begin
                // FCS negation outranks everything, including an ack on the same clock.
                if (bus.fcs_n) begin
                    state_d   = S_IDLE;
                    tgt_sel_d = '0;
                    abort_d   = 1'b1;
                end else if (wait_q != 8'd0) begin
                    wait_d = wait_q - 8'd1;
                end else if (|(bus.tgt_ack & tgt_sel_q)) begin
                    state_d = S_END;
                    dtack_d = 1'b1;
                end else if (TIMEOUT != 0 && to_q == TO_LAST) begin
                    state_d = S_ERR;
                    berr_d  = 1'b1;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                end else if (to_q != {TO_W{1'b1}}) begin
                    to_d = to_q + 1'b1;
                end
            end
            S_END: begin
                dtack_d = 1'b1;
                berr_d  = 1'b0;
                if (bus.fcs_n) begin
                    state_d   = S_IDLE;
                    dtack_d   = 1'b0;
                    tgt_sel_d = '0;
                end
            end
            S_ERR: begin
                berr_d  = 1'b1;
                dtack_d = 1'b0;
                if (bus.fcs_n) begin
                    state_d   = S_IDLE;
                    berr_d    = 1'b0;
                    tgt_sel_d = '0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                tgt_sel_d = '0;
                dtack_d   = 1'b0;
                berr_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tgt_sel_q   <= '0;
            dtack_q     <= 1'b0;
            berr_q      <= 1'b0;
            multi_hit_q <= 1'b0;
            abort_q     <= 1'b0;
            err_cnt_q   <= 8'd0;
            wait_q      <= 8'd0;
            to_q        <= '0;
        end else begin
            state_q     <= state_d;
            tgt_sel_q   <= tgt_sel_d;
            dtack_q     <= dtack_d;
            berr_q      <= berr_d;
            multi_hit_q <= multi_hit_d;
            abort_q     <= abort_d;
            err_cnt_q   <= err_cnt_d;
            wait_q      <= wait_d;
            to_q        <= to_d;
        end
    end

    assign bus.tgt_sel   = tgt_sel_q;
    assign bus.dtack     = dtack_q;
    assign bus.berr_req  = berr_q;
    assign bus.multi_hit = multi_hit_q;
    assign bus.abort     = abort_q;
    assign bus.err_count = err_cnt_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_z3_slave_sequencer.sv
// Directed bench for z3_slave_sequencer: expectations queued with the stimulus,
// popped and asserted when the corresponding DUT output is sampled.
module tb_z3_slave_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #20 clk = ~clk;

    z3_slave_sequencer_if #(.NUM_TGT(4)) i0 ();
    z3_slave_sequencer_if #(.NUM_TGT(4)) i1 ();

    z3_slave_sequencer #(.NUM_TGT(4), .MIN_WAIT(0), .TIMEOUT(8)) dut0 (
        .clk(clk), .rst(rst), .bus(i0)
    );
    z3_slave_sequencer #(.NUM_TGT(4), .MIN_WAIT(3), .TIMEOUT(8)) dut1 (
        .clk(clk), .rst(rst), .bus(i1)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_chk++;
        if (sb.size() == 0) begin
            $error("FAIL sb_empty: observed=%0h with no expectation queued", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        i0.fcs_n = 1'b1; i0.read = 1'b0; i0.ds_n = 4'hF; i0.validspace = 1'b1;
        i0.tgt_match = 4'b0; i0.tgt_ack = 4'b0;
    endtask

    task automatic idle1();
        i1.fcs_n = 1'b1; i1.read = 1'b0; i1.ds_n = 4'hF; i1.validspace = 1'b1;
        i1.tgt_match = 4'b0; i1.tgt_ack = 4'b0;
    endtask

    // Two edges: IDLE->START, START->DATA.
    task automatic start_read0(input logic [3:0] m);
        i0.fcs_n = 1'b0; i0.read = 1'b1; i0.tgt_match = m;
        step();
        step();
    endtask

    task automatic run_timeout0();
        start_read0(4'b0001);
        repeat (8) step();
        idle0();
        step();
    endtask

    initial begin
        idle0();
        idle1();
        #5;
        // reset values
        exp("rst_state", 0);    chk(32'(i0.state));
        exp("rst_sel", 0);      chk(32'(i0.tgt_sel));
        exp("rst_dtack", 0);    chk(32'(i0.dtack));
        exp("rst_berr", 0);     chk(32'(i0.berr_req));
        exp("rst_errcnt", 0);   chk(32'(i0.err_count));
        exp("rst_pulses", 0);   chk(32'({i0.multi_hit, i0.abort}));
        step();
        rst = 1'b0;
        step();

        // 1: read to target 2, ack three clocks into DATA
        i0.fcs_n = 1'b0; i0.read = 1'b1; i0.tgt_match = 4'b0100;
        step();
        exp("t1_start", 1);     chk(32'(i0.state));
        exp("t1_sel", 4'b0100); chk(32'(i0.tgt_sel));
        exp("t1_nomulti", 0);   chk(32'(i0.multi_hit));
        step();
        exp("t1_data", 2);      chk(32'(i0.state));
        step();
        step();
        exp("t1_noack", 0);     chk(32'(i0.dtack));
        i0.tgt_ack = 4'b0100;
        step();
        exp("t1_dtack", 1);     chk(32'(i0.dtack));
        exp("t1_end", 3);       chk(32'(i0.state));
        step();
        exp("t1_hold", 1);      chk(32'(i0.dtack));
        idle0();
        step();
        exp("t1_release", 0);   chk(32'({i0.dtack, i0.state, i0.tgt_sel}));

        // 2: write, strobes idle for five clocks
        i0.fcs_n = 1'b0; i0.read = 1'b0; i0.ds_n = 4'hF; i0.tgt_match = 4'b0001;
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            exp("t2_hold_start", 1); chk(32'(i0.state));
        end
        i0.ds_n = 4'h0;
        step();
        exp("t2_data", 2);      chk(32'(i0.state));
        i0.tgt_ack = 4'b0001;
        step();
        exp("t2_dtack", 1);     chk(32'(i0.dtack));
        idle0();
        step();

        // 4: timeout after 8 DATA clocks
        start_read0(4'b0001);
        repeat (7) step();
        exp("t4_pre_berr", 0);  chk(32'({i0.berr_req, i0.state}) ^ 32'd2);
        step();
        exp("t4_berr", 1);      chk(32'(i0.berr_req));
        exp("t4_err", 4);       chk(32'(i0.state));
        exp("t4_errcnt", 1);    chk(32'(i0.err_count));
        exp("t4_nodtack", 0);   chk(32'(i0.dtack));
        step();
        exp("t4_hold", 1);      chk(32'(i0.berr_req));
        idle0();
        step();
        exp("t4_clear", 0);     chk(32'({i0.berr_req, i0.state}));

        // 5: overlapping decode, ack only from the loser
        i0.fcs_n = 1'b0; i0.read = 1'b1; i0.tgt_match = 4'b0110; i0.tgt_ack = 4'b0100;
        step();
        exp("t5_sel", 4'b0010); chk(32'(i0.tgt_sel));
        exp("t5_multi", 1);     chk(32'(i0.multi_hit));
        step();
        exp("t5_multi_off", 0); chk(32'(i0.multi_hit));
        repeat (8) step();
        exp("t5_err", 4);       chk(32'(i0.state));
        exp("t5_nodtack", 0);   chk(32'(i0.dtack));
        exp("t5_errcnt", 2);    chk(32'(i0.err_count));
        idle0();
        step();

        // ack arriving on the expiry clock wins over the timeout
        start_read0(4'b1000);
        repeat (7) step();
        i0.tgt_ack = 4'b1000;
        step();
        exp("exp_ack_end", 3);  chk(32'(i0.state));
        exp("exp_ack_dtk", 2);  chk(32'({i0.dtack, i0.berr_req}));
        exp("exp_ack_cnt", 2);  chk(32'(i0.err_count));
        idle0();
        step();

        // 6a: FCS negation with ack on the same DATA clock
        start_read0(4'b0001);
        i0.fcs_n = 1'b1; i0.tgt_ack = 4'b0001;
        step();
        exp("t6_abort", 1);     chk(32'(i0.abort));
        exp("t6_idle", 0);      chk(32'({i0.dtack, i0.state}));
        idle0();
        step();
        exp("t6_abort_off", 0); chk(32'(i0.abort));

        // 3: MIN_WAIT=3 instance, ack held from DATA entry
        i1.fcs_n = 1'b0; i1.read = 1'b1; i1.tgt_match = 4'b0001; i1.tgt_ack = 4'b0001;
        step();
        step();
        exp("t3_data", 2);      chk(32'(i1.state));
        for (int k = 1; k <= 3; k++) begin
            step();
            exp("t3_wait", 0);  chk(32'(i1.dtack));
        end
        step();
        exp("t3_dtack", 1);     chk(32'(i1.dtack));
        idle1();
        step();

        // 6b: asynchronous reset while in END
        start_read0(4'b0001);
        i0.tgt_ack = 4'b0001;
        step();
        exp("t6b_end", 3);      chk(32'(i0.state));
        #5 rst = 1'b1;
        #1;
        exp("t6b_dtack", 0);    chk(32'(i0.dtack));
        exp("t6b_state", 0);    chk(32'(i0.state));
        idle0();
        step();
        rst = 1'b0;
        step();

        // err_count saturation
        repeat (255) run_timeout0();
        exp("sat_255", 255);    chk(32'(i0.err_count));
        run_timeout0();
        exp("sat_hold", 255);   chk(32'(i0.err_count));

        if (sb.size() != 0) begin
            n_chk++;
            $error("FAIL sb_leftover: observed=%0d expected=0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // dtack and berr_req must never overlap
    always @(negedge clk) begin
        if (!rst) begin
            assert (!(i0.dtack && i0.berr_req) && !(i1.dtack && i1.berr_req))
            else begin
                n_chk++;
                $error("FAIL dtack_berr_overlap: observed=1 expected=0");
            end
        end
    end
endmodule
